sprite_sched: RTL and testbench

- Sprite scheduler in the pixel clock domain. Owns a table of NSPR sprite slots holding position, horizontal velocity and enable.
- On each `frame` pulse it advances every sprite's position, with bounce at the off-screen margins.
- On each `line` pulse it scans the table and assigns up to LANES sprites that are visible on the next scanline to the sprite-engine lanes.
- Sits between the display timing generator (sx/sy, frame, line) and the per-lane sprite renderers. Slots are configured through a simple write port.

---
 rtl/sprite_sched.sv | 267 ++++++++++++++++++++++++++
 tb/tb_sprite_sched.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_sched.sv
// -----------------------------------------------------------------------------
// sprite_sched -- sprite slot table and per-line lane scheduler (clk_pix domain)
//
// Owns NSPR sprite slots (x, y, vx, enable). On a frame pulse every enabled
// slot is stepped horizontally, bouncing at the off-screen margins. On a line
// pulse the table is scanned for sprites covering the next scanline and up to
// LANES of them (lowest slot index first) are handed to the sprite-engine lanes.
//
// Ports
//   clk_pix, rst_pix_n     pixel clock, asynchronous active-low reset
//   frame, line            one-cycle start-of-frame / start-of-line pulses
//   sy                     current line (signed)
//   cfg_we/addr/field/data slot write port; field 0=x 1=y 2=vx 3=ctrl(bit0=en)
//   cfg_busy               high whenever the scheduler is not IDLE; writes
//                          are only taken while it is low
//   lane_valid/id/x/y      per-lane assignment, packed lane 0 in the LSBs
//   sched_done             one-cycle pulse when the lane outputs update
//   overflow               pulses with sched_done if hits exceeded LANES
//   ovf_count              (SPRITE_SCHED_STATS_EN only) overflowing commits in
//                          the current frame, saturating at 255
//
// Build option: define SPRITE_SCHED_STATS_EN to add the ovf_count output.
// -----------------------------------------------------------------------------
module sprite_sched #(
  parameter int  CORDW     = 16,
  parameter int  NSPR      = 8,
  parameter int  LANES     = 2,
  parameter int  H_RES     = 640,
  parameter int  V_RES     = 480,
  parameter int  SPR_DRAWW = 64,
  parameter int  SPR_DRAWH = 64,
  localparam int IDW       = $clog2(NSPR)
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  input  logic                    frame,
  input  logic                    line,
  input  logic signed [CORDW-1:0] sy,
  input  logic                    cfg_we,
  input  logic [IDW-1:0]          cfg_addr,
  input  logic [1:0]              cfg_field,
  input  logic signed [CORDW-1:0] cfg_data,
  output logic                    cfg_busy,
  output logic [LANES-1:0]        lane_valid,
  output logic [LANES*IDW-1:0]    lane_id,
  output logic [LANES*CORDW-1:0]  lane_x,
  output logic [LANES*CORDW-1:0]  lane_y,
  output logic                    sched_done,
  output logic                    overflow
`ifdef SPRITE_SCHED_STATS_EN
  ,
  output logic [7:0]              ovf_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_SCAN, S_COMMIT} state_t;

  // Motion compares run two bits wider so x + margins never wraps; the
  // visibility compare runs one bit wider so y + height never wraps.
  localparam int MW   = CORDW + 2;
  localparam int SW   = CORDW + 1;
  localparam int CNTW = $clog2(LANES + 1);

  localparam logic [IDW-1:0]          LAST_IDX  = IDW'(NSPR - 1);
  localparam logic signed [MW-1:0]    W_M       = MW'(SPR_DRAWW);
  localparam logic signed [MW-1:0]    X_HI      = MW'(H_RES + 2 * SPR_DRAWW);
  localparam logic signed [MW-1:0]    X_LO      = MW'(-2 * SPR_DRAWW);
  localparam logic signed [SW-1:0]    H_S       = SW'(SPR_DRAWH);
  localparam logic signed [CORDW-1:0] LAST_LINE = CORDW'(V_RES - 1);

  // The scan always looks one line ahead; the last visible line wraps to 0.
  function automatic logic signed [CORDW-1:0] next_line(input logic signed [CORDW-1:0] s);
    return (s == LAST_LINE) ? '0 : s + CORDW'(1);
  endfunction

  state_t state, state_nxt;

  // Slot table
  logic signed [CORDW-1:0] slot_x  [NSPR];
  logic signed [CORDW-1:0] slot_y  [NSPR];
  logic signed [CORDW-1:0] slot_vx [NSPR];
  logic [NSPR-1:0]         slot_en;

  // Sequencing
  logic [IDW-1:0]          idx;
  logic signed [CORDW-1:0] target;
  logic signed [CORDW-1:0] pend_tgt;
  logic                    line_pend;
  logic                    frame_pend;

  // Shadow lanes, built during SCAN and published in COMMIT
  logic [LANES-1:0]        sh_valid;
  logic [IDW-1:0]          sh_id [LANES];
  logic signed [CORDW-1:0] sh_x  [LANES];
  logic signed [CORDW-1:0] sh_y  [LANES];
  logic [CNTW-1:0]         sh_cnt;
  logic                    sh_ovf;

  // Shared decode
  logic                    last_idx, want_frame, want_line;
  logic                    start_move, start_scan;
  logic signed [CORDW-1:0] scan_tgt;

  assign last_idx   = (idx == LAST_IDX);
  assign want_frame = frame | frame_pend;
  assign want_line  = line | line_pend;
  assign start_move = (state == S_IDLE) && want_frame;
  assign start_scan = ((state == S_IDLE) && !want_frame && want_line) ||
                      ((state == S_MOVE) && last_idx && want_line);
  // A line pulse arriving on the very cycle a scan starts is the newest one.
  assign scan_tgt   = line ? next_line(sy) : pend_tgt;

  // Motion step for the slot under idx
  logic signed [CORDW-1:0] cur_x, cur_vx;
  logic signed [MW-1:0]    cur_xe;
  logic                    vx_pos, vx_neg, bounce;

  assign cur_x  = slot_x[idx];
  assign cur_vx = slot_vx[idx];
  assign cur_xe = {{2{cur_x[CORDW-1]}}, cur_x};
  assign vx_neg = cur_vx[CORDW-1];
  assign vx_pos = !cur_vx[CORDW-1] && (cur_vx != '0);
  assign bounce = (vx_pos && (cur_xe + W_M >= X_HI)) || (vx_neg && (cur_xe <= X_LO));

  // Visibility test for the slot under idx
  logic signed [SW-1:0] tgt_e, y_e, y_end;
  logic                 hit;

  assign tgt_e = {target[CORDW-1], target};
  assign y_e   = {slot_y[idx][CORDW-1], slot_y[idx]};
  assign y_end = y_e + H_S;
  assign hit   = slot_en[idx] && (tgt_e >= y_e) && (tgt_e < y_end);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cfg_busy  = 1'b1;
    unique case (state)
      S_IDLE: begin
        cfg_busy = 1'b0;
        if (want_frame)     state_nxt = S_MOVE;
        else if (want_line) state_nxt = S_SCAN;
      end
      S_MOVE:   if (last_idx) state_nxt = want_line ? S_SCAN : S_IDLE;
      S_SCAN:   if (last_idx) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Slot table: config writes in IDLE, motion updates in MOVE.
  // NOTE: the table is a flop array, not a RAM, because it must read back as
  // zero immediately on reset; do not map it onto a memory macro.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      for (int i = 0; i < NSPR; i++) begin
        slot_x[i]  <= '0;
        slot_y[i]  <= '0;
        slot_vx[i] <= '0;
      end
      slot_en <= '0;
    end else if (state == S_IDLE && cfg_we) begin
      unique case (cfg_field)
        2'd0: slot_x[cfg_addr]  <= cfg_data;
        2'd1: slot_y[cfg_addr]  <= cfg_data;
        2'd2: slot_vx[cfg_addr] <= cfg_data;
        2'd3: slot_en[cfg_addr] <= cfg_data[0];
        default: ;
      endcase
    end else if (state == S_MOVE && slot_en[idx]) begin
      if (bounce) slot_vx[idx] <= -cur_vx;
      else        slot_x[idx]  <= cur_x + cur_vx;
    end
  end

  // Sequencing, pending requests, shadow lanes and published outputs
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      idx        <= '0;
      target     <= '0;
      pend_tgt   <= '0;
      line_pend  <= 1'b0;
      frame_pend <= 1'b0;
      sh_valid   <= '0;
      sh_cnt     <= '0;
      sh_ovf     <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        sh_id[l] <= '0;
        sh_x[l]  <= '0;
        sh_y[l]  <= '0;
      end
      lane_valid <= '0;
      lane_id    <= '0;
      lane_x     <= '0;
      lane_y     <= '0;
      sched_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (state == S_MOVE || state == S_SCAN) idx <= last_idx ? '0 : idx + 1'b1;
      else                                    idx <= '0;

      if (start_move) frame_pend <= 1'b0;
      else if (frame) frame_pend <= 1'b1;

      if (start_scan) begin
        target    <= scan_tgt;
        line_pend <= 1'b0;
      end else if (line) begin
        line_pend <= 1'b1;
        pend_tgt  <= next_line(sy);
      end

      if (start_scan) begin
        sh_valid <= '0;
        sh_cnt   <= '0;
        sh_ovf   <= 1'b0;
        for (int l = 0; l < LANES; l++) begin
          sh_id[l] <= '0;
          sh_x[l]  <= '0;
          sh_y[l]  <= '0;
        end
      end else if (state == S_SCAN && hit) begin
        if (sh_cnt == CNTW'(LANES)) begin
          sh_ovf <= 1'b1;
        end else begin
          for (int l = 0; l < LANES; l++) begin
            if (sh_cnt == CNTW'(l)) begin
              sh_valid[l] <= 1'b1;
              sh_id[l]    <= idx;
              sh_x[l]     <= slot_x[idx];
              sh_y[l]     <= slot_y[idx];
            end
          end
          sh_cnt <= sh_cnt + 1'b1;
        end
      end

      sched_done <= (state == S_COMMIT);
      overflow   <= (state == S_COMMIT) && sh_ovf;
      if (state == S_COMMIT) begin
        for (int l = 0; l < LANES; l++) begin
          lane_valid[l]                <= sh_valid[l];
          lane_id[l*IDW +: IDW]        <= sh_id[l];
          lane_x[l*CORDW +: CORDW]     <= sh_x[l];
          lane_y[l*CORDW +: CORDW]     <= sh_y[l];
        end
      end
    end
  end

`ifdef SPRITE_SCHED_STATS_EN
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n)                                           ovf_count <= '0;
    else if (start_move)                                      ovf_count <= '0;
    else if (state == S_COMMIT && sh_ovf && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_sprite_sched.sv
// -----------------------------------------------------------------------------
// tb_sprite_sched -- self-checking bench for sprite_sched (default parameters)
//
// Directed table of scanline vectors, hand-written multi-cycle sequences
// (reset mid-scan, motion/bounce, frame+line collision, pending line, ignored
// writes) and a randomized phase compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_sprite_sched;

  localparam int CORDW = 16;
  localparam int NSPR  = 8;
  localparam int LANES = 2;
  localparam int IDW   = 3;

  logic                    clk_pix   = 1'b0;
  logic                    rst_pix_n = 1'b0;
  logic                    frame     = 1'b0;
  logic                    line      = 1'b0;
  logic signed [CORDW-1:0] sy        = '0;
  logic                    cfg_we    = 1'b0;
  logic [IDW-1:0]          cfg_addr  = '0;
  logic [1:0]              cfg_field = '0;
  logic signed [CORDW-1:0] cfg_data  = '0;
  logic                    cfg_busy;
  logic [LANES-1:0]        lane_valid;
  logic [LANES*IDW-1:0]    lane_id;
  logic [LANES*CORDW-1:0]  lane_x, lane_y;
  logic                    sched_done, overflow;
`ifdef SPRITE_SCHED_STATS_EN
  logic [7:0]              ovf_count;
`endif

  always #5 clk_pix = ~clk_pix;

  sprite_sched #(.CORDW(CORDW), .NSPR(NSPR), .LANES(LANES)) dut (
    .clk_pix    (clk_pix),
    .rst_pix_n  (rst_pix_n),
    .frame      (frame),
    .line       (line),
    .sy         (sy),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_field  (cfg_field),
    .cfg_data   (cfg_data),
    .cfg_busy   (cfg_busy),
    .lane_valid (lane_valid),
    .lane_id    (lane_id),
    .lane_x     (lane_x),
    .lane_y     (lane_y),
    .sched_done (sched_done),
    .overflow   (overflow)
`ifdef SPRITE_SCHED_STATS_EN
    ,
    .ovf_count  (ovf_count)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int   m_x [NSPR];
  int   m_y [NSPR];
  int   m_vx[NSPR];
  bit   m_en[NSPR];
  logic [1:0] e_v;
  int   e_id[2], e_x[2], e_y[2];
  logic e_ovf;

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NSPR; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_en[i] = 0;
    end
  endtask

  task automatic model_frame();
    for (int i = 0; i < NSPR; i++) begin
      if (m_en[i]) begin
        if (m_vx[i] > 0 && m_x[i] + 64 >= 640 + 128)   m_vx[i] = wrap16(-m_vx[i]);
        else if (m_vx[i] < 0 && m_x[i] <= -128)        m_vx[i] = wrap16(-m_vx[i]);
        else                                           m_x[i]  = wrap16(m_x[i] + m_vx[i]);
      end
    end
  endtask

  task automatic model_line(input int s);
    int tgt, cnt;
    tgt = (s == 479) ? 0 : s + 1;
    e_v = '0; e_ovf = 1'b0; cnt = 0;
    for (int l = 0; l < 2; l++) begin e_id[l] = 0; e_x[l] = 0; e_y[l] = 0; end
    for (int i = 0; i < NSPR; i++) begin
      if (m_en[i] && tgt >= m_y[i] && tgt < m_y[i] + 64) begin
        if (cnt < 2) begin
          e_v[cnt] = 1'b1; e_id[cnt] = i; e_x[cnt] = m_x[i]; e_y[cnt] = m_y[i];
          cnt++;
        end else e_ovf = 1'b1;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cfg_write(input int a, input int f, input int d);
    @(negedge clk_pix);
    cfg_we = 1'b1; cfg_addr = a[IDW-1:0]; cfg_field = f[1:0]; cfg_data = d[15:0];
    @(posedge clk_pix);
    @(negedge clk_pix);
    cfg_we = 1'b0;
  endtask

  task automatic set_slot(input int i, input int x, input int y, input int vx, input int en);
    cfg_write(i, 0, x);
    cfg_write(i, 1, y);
    cfg_write(i, 2, vx);
    cfg_write(i, 3, en);
    m_x[i] = wrap16(x); m_y[i] = wrap16(y); m_vx[i] = wrap16(vx); m_en[i] = en[0];
  endtask

  task automatic do_reset();
    @(negedge clk_pix);
    rst_pix_n = 1'b0;
    repeat (2) @(posedge clk_pix);
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    model_reset();
  endtask

  // Pulses line at edge N and returns the number of edges after N at which
  // sched_done was seen (-1 if it never came).
  task automatic run_line(input int s, output int lat);
    @(negedge clk_pix);
    line = 1'b1; sy = s[15:0];
    @(posedge clk_pix);
    @(negedge clk_pix);
    line = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk_pix);
      @(negedge clk_pix);
      if (sched_done) begin lat = c; break; end
    end
  endtask

  task automatic run_frame(output int busy_cycles);
    @(negedge clk_pix);
    frame = 1'b1;
    @(posedge clk_pix);
    @(negedge clk_pix);
    frame = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      if (!cfg_busy) break;
      busy_cycles++;
      @(posedge clk_pix);
      @(negedge clk_pix);
    end
    check("frame_idle", {63'd0, cfg_busy}, 64'd0);
    model_frame();
  endtask

  task automatic check_lanes(input string tag, input logic [1:0] v, input int id0, input int id1,
                             input int x0, input int x1, input int y0, input int y1,
                             input logic ovf);
    logic [5:0]  eid;
    logic [15:0] a, b;
    logic [31:0] ex, ey;
    eid = {id1[2:0], id0[2:0]};
    a = x1[15:0]; b = x0[15:0]; ex = {a, b};
    a = y1[15:0]; b = y0[15:0]; ey = {a, b};
    check({tag, ".valid"}, {62'd0, lane_valid}, {62'd0, v});
    check({tag, ".id"},    {58'd0, lane_id},    {58'd0, eid});
    check({tag, ".x"},     {32'd0, lane_x},     {32'd0, ex});
    check({tag, ".y"},     {32'd0, lane_y},     {32'd0, ey});
    check({tag, ".ovf"},   {63'd0, overflow},   {63'd0, ovf});
  endtask

  typedef struct {
    int         sy;
    logic [1:0] v;
    int         id0, id1, x0, x1, y0, y1;
    logic       ovf;
  } vec_t;

  vec_t tbl[10];
  int   lat, busy, first_idle, done1, done2;

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state ----------------
    model_reset();
    repeat (3) @(posedge clk_pix);
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    @(negedge clk_pix);
    check("reset.valid", {62'd0, lane_valid}, 64'd0);
    check("reset.busy",  {63'd0, cfg_busy},   64'd0);
    check("reset.done",  {63'd0, sched_done}, 64'd0);
    check("reset.x",     {32'd0, lane_x},     64'd0);

    // ---------------- table-driven visibility ----------------
    set_slot(0, 288, 100, 0, 1);
    set_slot(1,  11, 200, 0, 1);
    set_slot(2,  10,   0, 0, 1);
    set_slot(3,  33, 200, 0, 1);
    set_slot(4, 500, 100, 0, 0);
    set_slot(5,  55, 200, 0, 1);
    set_slot(6,  66, 120, 0, 1);
    set_slot(7, -50, -30, 0, 1);

    tbl[0] = '{ 99, 2'b01, 0, 0, 288,   0, 100,   0, 1'b0};
    tbl[1] = '{163, 2'b01, 6, 0,  66,   0, 120,   0, 1'b0};
    tbl[2] = '{162, 2'b11, 0, 6, 288,  66, 100, 120, 1'b0};
    tbl[3] = '{183, 2'b00, 0, 0,   0,   0,   0,   0, 1'b0};
    tbl[4] = '{479, 2'b11, 2, 7,  10, -50,   0, -30, 1'b0};
    tbl[5] = '{ 33, 2'b01, 2, 0,  10,   0,   0,   0, 1'b0};
    tbl[6] = '{199, 2'b11, 1, 3,  11,  33, 200, 200, 1'b1};
    tbl[7] = '{210, 2'b11, 1, 3,  11,  33, 200, 200, 1'b1};
    tbl[8] = '{198, 2'b00, 0, 0,   0,   0,   0,   0, 1'b0};
    tbl[9] = '{ -1, 2'b11, 2, 7,  10, -50,   0, -30, 1'b0};

    for (int t = 0; t < 10; t++) begin
      run_line(tbl[t].sy, lat);
      check($sformatf("tbl%0d.latency", t), 64'(lat), 64'd9);
      check_lanes($sformatf("tbl%0d", t), tbl[t].v, tbl[t].id0, tbl[t].id1,
                  tbl[t].x0, tbl[t].x1, tbl[t].y0, tbl[t].y1, tbl[t].ovf);
    end

    // ---------------- reset mid-SCAN ----------------
    @(negedge clk_pix);
    line = 1'b1; sy = 16'sd99;
    @(posedge clk_pix);
    @(negedge clk_pix);
    line = 1'b0;
    repeat (3) begin @(posedge clk_pix); @(negedge clk_pix); end
    #2 rst_pix_n = 1'b0;
    #1;
    check("midscan_rst.valid", {62'd0, lane_valid}, 64'd0);
    check("midscan_rst.id",    {58'd0, lane_id},    64'd0);
    check("midscan_rst.x",     {32'd0, lane_x},     64'd0);
    check("midscan_rst.busy",  {63'd0, cfg_busy},   64'd0);
    @(posedge clk_pix);
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    model_reset();
    @(negedge clk_pix);
    check("post_rst.done", {63'd0, sched_done}, 64'd0);
    run_line(99, lat);
    check("post_rst.latency", 64'(lat), 64'd9);
    check("post_rst.valid", {62'd0, lane_valid}, 64'd0);

    // ---------------- motion and bounce ----------------
    set_slot(0,  636, 100,  4, 1);
    set_slot(1,  704, 100,  4, 1);
    set_slot(2, -128, 300, -4, 1);
    set_slot(3,   50, 300,  7, 0);
    run_frame(busy);
    check("move.busy_cycles", 64'(busy), 64'd8);
    run_line(99, lat);
    check_lanes("move1", 2'b11, 0, 1, 640, 704, 100, 100, 1'b0);
    run_frame(busy);
    run_line(99, lat);
    check_lanes("move2", 2'b11, 0, 1, 644, 700, 100, 100, 1'b0);
    run_line(299, lat);
    check_lanes("move2b", 2'b01, 2, 0, -124, 0, 300, 0, 1'b0);
    cfg_write(3, 3, 1);
    m_en[3] = 1'b1;
    run_line(299, lat);
    check_lanes("disabled_kept", 2'b11, 2, 3, -124, 50, 300, 300, 1'b0);

    // ---------------- frame + line together, write while busy, pending line ----
    @(negedge clk_pix);
    frame = 1'b1; line = 1'b1; sy = 16'sd99;
    @(posedge clk_pix);
    @(negedge clk_pix);
    frame = 1'b0; line = 1'b0;
    first_idle = -1; done1 = -1; done2 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_pix);
      @(negedge clk_pix);
      cfg_we = 1'b0; line = 1'b0;
      if (first_idle < 0 && !cfg_busy) first_idle = k;
      if (sched_done) begin
        if (done1 < 0) begin
          done1 = k;
          check_lanes("collide_first", 2'b11, 0, 1, 648, 696, 100, 100, 1'b0);
        end else if (done2 < 0) begin
          done2 = k;
          check_lanes("collide_pend", 2'b11, 2, 3, -120, 57, 300, 300, 1'b0);
        end
      end
      if (k == 3) begin cfg_we = 1'b1; cfg_addr = 3'd0; cfg_field = 2'd0; cfg_data = 16'sd0; end
      if (k == 10) begin line = 1'b1; sy = 16'sd299; end
    end
    model_frame();
    check("collide.busy_cycles", 64'(first_idle), 64'd17);
    check("collide.done1_at",    64'(done1),      64'd17);
    check("collide.done2_at",    64'(done2),      64'd27);
    run_line(99, lat);
    check_lanes("busy_write_ignored", 2'b11, 0, 1, 648, 696, 100, 100, 1'b0);

`ifdef SPRITE_SCHED_STATS_EN
    // ---------------- overflow statistics ----------------
    do_reset();
    set_slot(1, 11, 200, 0, 1);
    set_slot(3, 33, 200, 0, 1);
    set_slot(5, 55, 200, 0, 1);
    run_frame(busy);
    check("stats.after_frame", 64'(ovf_count), 64'd0);
    for (int n = 0; n < 3; n++) begin
      run_line(210, lat);
      check("stats.ovf_pulse", {63'd0, overflow}, 64'd1);
    end
    check("stats.count3", 64'(ovf_count), 64'd3);
    run_frame(busy);
    check("stats.cleared", 64'(ovf_count), 64'd0);
`endif

    // ---------------- randomized against the model ----------------
    do_reset();
    for (int i = 0; i < NSPR; i++)
      set_slot(i, int'($urandom_range(0, 1000)) - 200, int'($urandom_range(0, 600)) - 80,
               int'($urandom_range(0, 16)) - 8, int'($urandom_range(0, 3) != 0));
    for (int it = 0; it < 60; it++) begin
      int r, s, a, f, d;
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        run_frame(busy);
      end else if (r < 3) begin
        a = int'($urandom_range(0, NSPR - 1));
        f = int'($urandom_range(0, 3));
        d = (f == 3) ? int'($urandom_range(0, 7)) :
            (f == 2) ? int'($urandom_range(0, 16)) - 8 : int'($urandom_range(0, 900)) - 150;
        cfg_write(a, f, d);
        case (f)
          0: m_x[a]  = wrap16(d);
          1: m_y[a]  = wrap16(d);
          2: m_vx[a] = wrap16(d);
          default: m_en[a] = d[0];
        endcase
      end else begin
        s = int'($urandom_range(0, 560)) - 70;
        run_line(s, lat);
        model_line(s);
        check($sformatf("rand%0d.latency", it), 64'(lat), 64'd9);
        check_lanes($sformatf("rand%0d", it), e_v, e_id[0], e_id[1], e_x[0], e_x[1],
                    e_y[0], e_y[1], e_ovf);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
